dma_mc: RTL and testbench

Multi-channel, parametrised DMA engine for the HOKSTER bus. It is the successor to the single-channel DMA. Software programs per-channel source, destination and length registers over the aux store bus. The engine then copies data memory-to-memory on the external data bus, arbitrating round-robin between active channels, and raises one interrupt line while any channel has a completion pending.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_rr_arbiter.sv | 29 ++
 rtl/dma_mc.sv | 213 +++++++++++++++++++++
 tb/tb_dma_mc.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: register map, ctrl bits, FSM states and block size
// shared by the multi-channel DMA engine (dma_mc).
package dma_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_SRC_LO = 3'd1;
    localparam logic [2:0] OFF_SRC_HI = 3'd2;
    localparam logic [2:0] OFF_DST_LO = 3'd3;
    localparam logic [2:0] OFF_DST_HI = 3'd4;
    localparam logic [2:0] OFF_LEN    = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_SFIX  = 1;
    localparam int CTRL_DFIX  = 2;
    localparam int CTRL_ABORT = 7;

    localparam int BLK_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_READ,
        S_WRITE
    } dma_state_e;

endpackage

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin grant, searching
// from the channel after the last granted one.
module dma_rr_arbiter #(
    parameter int NCH = 2,
    parameter int PW  = 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic           vld_o
);

    int idx;

    // First requester after ptr_i, wrapping; ptr_i itself is checked last.
    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(ptr_i) + i) % NCH;
            if (!vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_mc.sv
// dma_mc: multi-channel memory-to-memory DMA with round-robin blocks.
// Option macro DMA_MC_BURST_EN: granted channel keeps the bus to the end.
module dma_mc
    import dma_pkg::*;
#(
    parameter int          NCH  = 2,
    parameter int          AW   = 16,
    parameter int          CW   = 8,
    parameter logic [15:0] BASE = 16'h0100
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [15:0]    auxdaddr,
    input  logic [7:0]     auxdin,
    input  logic           auxwe,
    input  logic [7:0]     extdout,
    input  logic [NCH-1:0] ack,
    output logic           irq,
    output logic           auxdoutsel,
    output logic [7:0]     extdin,
    output logic [AW-1:0]  extdaddr,
    output logic           extwe,
    output logic [NCH-1:0] busy
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RW = CW + 2;

    logic [AW-1:0]  src_q [NCH];
    logic [AW-1:0]  dst_q [NCH];
    logic [CW-1:0]  len_q [NCH];
    logic [RW-1:0]  rem_q [NCH];
    logic [NCH-1:0] sfix_q, dfix_q, busy_q, done_q, abrt_q;

    dma_state_e     state_q;
    logic [PW-1:0]  cur_q, ptr_q;
    logic [1:0]     bcnt_q;

    logic [15:0]    rel;
    logic           hit;
    logic [2:0]     off;
    logic [NCH-1:0] wsel, ctrl_wr, abort_now, start_now, own, kill;
    logic [NCH-1:0] gnt;
    logic           gnt_vld;
    logic [PW-1:0]  gidx;
    logic           wr_end, last;

    assign rel = auxdaddr - BASE;
    assign off = rel[2:0];
    assign hit = auxwe && (auxdaddr >= BASE) && (rel < 16'(8 * NCH));

    assign wr_end = (state_q == S_WRITE);
    assign last   = (rem_q[cur_q] == RW'(1));

    // Per-channel write decode and abort/start qualification.
    always_comb begin
        wsel      = '0;
        ctrl_wr   = '0;
        abort_now = '0;
        start_now = '0;
        own       = '0;
        kill      = '0;
        for (int c = 0; c < NCH; c++) begin
            wsel[c]      = hit && (rel[15:3] == 13'(c));
            ctrl_wr[c]   = wsel[c] && (off == OFF_CTRL);
            abort_now[c] = ctrl_wr[c] && auxdin[CTRL_ABORT];
            start_now[c] = ctrl_wr[c] && auxdin[CTRL_START]
                           && !auxdin[CTRL_ABORT] && !busy_q[c];
            own[c]       = ((state_q == S_READ) || (state_q == S_WRITE))
                           && (cur_q == PW'(c));
            // An owned channel stops only once its current byte is written.
            kill[c]      = busy_q[c] && (abrt_q[c] || abort_now[c])
                           && (!own[c] || wr_end);
        end
    end

    dma_rr_arbiter #(
        .NCH (NCH),
        .PW  (PW)
    ) u_arb (
        .req_i (busy_q & ~abort_now),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .vld_o (gnt_vld)
    );

    // One-hot grant to channel index.
    always_comb begin
        gidx = '0;
        for (int c = 0; c < NCH; c++) begin
            if (gnt[c]) gidx = PW'(c);
        end
    end

    // Channel registers: programming, start/abort, address advance, done.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
                rem_q[c] <= '0;
            end
            sfix_q <= '0;
            dfix_q <= '0;
            busy_q <= '0;
            done_q <= '0;
            abrt_q <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ack[c]) done_q[c] <= 1'b0;
                if (wr_end && (cur_q == PW'(c))) begin
                    if (!sfix_q[c]) src_q[c] <= src_q[c] + AW'(1);
                    if (!dfix_q[c]) dst_q[c] <= dst_q[c] + AW'(1);
                    rem_q[c] <= rem_q[c] - RW'(1);
                    if (last && !kill[c]) begin
                        busy_q[c] <= 1'b0;
                        done_q[c] <= 1'b1;
                    end
                end
                if (kill[c]) begin
                    busy_q[c] <= 1'b0;
                    abrt_q[c] <= 1'b0;
                end else if (abort_now[c] && busy_q[c]) begin
                    abrt_q[c] <= 1'b1;
                end
                if (start_now[c]) begin
                    busy_q[c] <= 1'b1;
                    sfix_q[c] <= auxdin[CTRL_SFIX];
                    dfix_q[c] <= auxdin[CTRL_DFIX];
                    rem_q[c]  <= RW'({len_q[c], 2'b00}) + RW'(4);
                end
                if (wsel[c] && !busy_q[c]) begin
                    unique case (off)
                        OFF_SRC_LO: src_q[c] <= (src_q[c] & ~AW'(16'h00FF))
                                                | AW'(auxdin);
                        OFF_SRC_HI: src_q[c] <= (src_q[c] & ~AW'(16'hFF00))
                                                | AW'({auxdin, 8'h00});
                        OFF_DST_LO: dst_q[c] <= (dst_q[c] & ~AW'(16'h00FF))
                                                | AW'(auxdin);
                        OFF_DST_HI: dst_q[c] <= (dst_q[c] & ~AW'(16'hFF00))
                                                | AW'({auxdin, 8'h00});
                        OFF_LEN:    len_q[c] <= CW'(auxdin);
                        default:    ;
                    endcase
                end
            end
        end
    end

    // Bus sequencer: arbitrate, then READ/WRITE byte pairs per block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|busy_q) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (gnt_vld) begin
                        cur_q   <= gidx;
                        ptr_q   <= gidx;
                        bcnt_q  <= '0;
                        state_q <= S_READ;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    bcnt_q <= bcnt_q + 2'd1;
                    if (!busy_q[cur_q] || last || kill[cur_q]) begin
                        state_q <= S_ARB;
`ifdef DMA_MC_BURST_EN
                    end else begin
                        state_q <= S_READ;
                    end
`else
                    end else if (bcnt_q == 2'(BLK_BYTES - 1)) begin
                        state_q <= S_ARB;
                    end else begin
                        state_q <= S_READ;
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // External bus drive, decoded from the current state.
    always_comb begin
        auxdoutsel = (state_q == S_READ) || (state_q == S_WRITE);
        extwe      = (state_q == S_WRITE);
        extdaddr   = '0;
        extdin     = '0;
        if (state_q == S_READ)  extdaddr = src_q[cur_q];
        if (state_q == S_WRITE) begin
            extdaddr = dst_q[cur_q];
            extdin   = extdout;
        end
    end

    assign irq  = |done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_dma_mc.sv
// tb_dma_mc: directed checks of dma_mc against a behavioural
// synchronous-read memory and logged bus traffic.
module tb_dma_mc;

    logic        clk;
    logic        rst;
    logic [15:0] auxdaddr;
    logic [7:0]  auxdin;
    logic        auxwe;
    logic [7:0]  extdout;
    logic [1:0]  ack;
    logic        irq;
    logic        auxdoutsel;
    logic [7:0]  extdin;
    logic [15:0] extdaddr;
    logic        extwe;
    logic [1:0]  busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  mem [65536];
    logic [15:0] wa [$];
    logic [7:0]  wd [$];
    int          wc [$];
    logic [15:0] ra [$];
    int          rc [$];

    dma_mc #(
        .NCH  (2),
        .AW   (16),
        .CW   (8),
        .BASE (16'h0100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .auxdaddr   (auxdaddr),
        .auxdin     (auxdin),
        .auxwe      (auxwe),
        .extdout    (extdout),
        .ack        (ack),
        .irq        (irq),
        .auxdoutsel (auxdoutsel),
        .extdin     (extdin),
        .extdaddr   (extdaddr),
        .extwe      (extwe),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory.
    always @(posedge clk) begin
        if (extwe) mem[extdaddr] <= extdin;
        extdout <= mem[extdaddr];
    end

    // Bus traffic log, sampled mid-cycle.
    always @(negedge clk) begin
        if (extwe) begin
            wa.push_back(extdaddr);
            wd.push_back(extdin);
            wc.push_back(cyc);
        end
        if (auxdoutsel && !extwe) begin
            ra.push_back(extdaddr);
            rc.push_back(cyc);
        end
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete();
        ra.delete(); rc.delete();
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        auxdaddr = a;
        auxdin   = d;
        auxwe    = 1'b1;
        @(posedge clk);
        #1;
        auxwe    = 1'b0;
    endtask

    task automatic prog(input int ch, input logic [15:0] s,
                        input logic [15:0] d, input logic [7:0] n);
        logic [15:0] b;
        b = 16'h0100 + 16'(8 * ch);
        wr_reg(b + 16'd1, s[7:0]);
        wr_reg(b + 16'd2, s[15:8]);
        wr_reg(b + 16'd3, d[7:0]);
        wr_reg(b + 16'd4, d[15:8]);
        wr_reg(b + 16'd5, n);
    endtask

    task automatic do_ack(input logic [1:0] m);
        @(negedge clk);
        #1;
        ack = m;
        @(posedge clk);
        #1;
        ack = 2'b00;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("FAIL %s timeout busy=%b required 00", nm, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL rst_irq got %b want 0", irq);
        end
        checks++;
        if (auxdoutsel !== 1'b0) begin
            errors++; $display("FAIL rst_sel got %b want 0", auxdoutsel);
        end
        checks++;
        if (extwe !== 1'b0) begin
            errors++; $display("FAIL rst_we got %b want 0", extwe);
        end
        checks++;
        if (extdaddr !== 16'h0) begin
            errors++; $display("FAIL rst_addr got %h want 0000", extdaddr);
        end
        checks++;
        if (extdin !== 8'h0) begin
            errors++; $display("FAIL rst_din got %h want 00", extdin);
        end
        checks++;
        if (busy !== 2'b00) begin
            errors++; $display("FAIL rst_busy got %b want 00", busy);
        end
    endtask

    task automatic test_single();
        int t;
        int first_irq;
        int gap;
        clear_logs();
        prog(0, 16'h0020, 16'h0030, 8'd3);
        wr_reg(16'h0100, 8'h01);
        t = cyc;
        checks++;
        if (busy !== 2'b01) begin
            errors++; $display("FAIL single_busy got %b want 01", busy);
        end
        first_irq = -1;
        while (cyc < t + 38) begin
            @(negedge clk);
            if (irq === 1'b1 && first_irq < 0) first_irq = cyc;
        end
        checks++;
        if (rc.size() == 0 || rc[0] != t + 2) begin
            errors++;
            $display("FAIL single_rd_cycle got %0d want %0d",
                     (rc.size() > 0) ? rc[0] - t : -1, 2);
        end
        checks++;
        if (ra.size() == 0 || ra[0] !== 16'h0020) begin
            errors++; $display("FAIL single_rd_addr want 0020");
        end
        checks++;
        if (first_irq < t + 37 || first_irq > t + 38) begin
            errors++;
            $display("FAIL single_irq_time got t+%0d want t+37..t+38",
                     first_irq - t);
        end
        checks++;
        if (irq !== 1'b1 || busy !== 2'b00) begin
            errors++;
            $display("FAIL single_end irq=%b busy=%b want 1 00", irq, busy);
        end
        checks++;
        if (wa.size() != 16) begin
            errors++; $display("FAIL single_count got %0d want 16", wa.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= wa.size() ||
                {wa[i], wd[i]} !== {16'h0030 + 16'(i), pat(16'h0020 + 16'(i))}) begin
                errors++;
                $display("FAIL single_wr%0d want %h/%h", i,
                         16'h0030 + 16'(i), pat(16'h0020 + 16'(i)));
            end
        end
`ifdef DMA_MC_BURST_EN
        gap = 2;
`else
        gap = 3;
`endif
        checks++;
        if (wc.size() < 5 || wc[4] - wc[3] != gap) begin
            errors++; $display("FAIL single_block_gap want %0d", gap);
        end
        do_ack(2'b01);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL single_ack irq got %b want 0", irq);
        end
    endtask

    // Last grant is channel 0, so round-robin serves channel 1 first.
    task automatic test_dual();
        clear_logs();
        prog(0, 16'h0040, 16'h0080, 8'd0);
        prog(1, 16'h0050, 16'h0090, 8'd0);
        wr_reg(16'h0100, 8'h01);
        wr_reg(16'h0108, 8'h01);
        wait_idle("dual");
        checks++;
        if (wa.size() != 8) begin
            errors++; $display("FAIL dual_count got %0d want 8", wa.size());
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ea;
            logic [7:0]  ed;
            ea = (i < 4) ? 16'h0090 + 16'(i) : 16'h0080 + 16'(i - 4);
            ed = (i < 4) ? pat(16'h0050 + 16'(i)) : pat(16'h0040 + 16'(i - 4));
            checks++;
            if (i >= wa.size() || {wa[i], wd[i]} !== {ea, ed}) begin
                errors++; $display("FAIL dual_wr%0d want %h/%h", i, ea, ed);
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL dual_irq got %b want 1", irq);
        end
        do_ack(2'b01);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL dual_ack0 irq got %b want 1", irq);
        end
        do_ack(2'b10);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL dual_ack1 irq got %b want 0", irq);
        end
    endtask

    task automatic test_dst_fixed();
        clear_logs();
        prog(0, 16'h0060, 16'h00F0, 8'd0);
        wr_reg(16'h0100, 8'h05);
        wait_idle("fixed");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wa.size() ||
                {wa[i], wd[i]} !== {16'h00F0, pat(16'h0060 + 16'(i))}) begin
                errors++; $display("FAIL fixed_wr%0d want 00f0/%h", i,
                                   pat(16'h0060 + 16'(i)));
            end
        end
        checks++;
        if (mem[16'h00F0] !== pat(16'h0063)) begin
            errors++; $display("FAIL fixed_mem got %h want %h",
                               mem[16'h00F0], pat(16'h0063));
        end
        do_ack(2'b01);
    endtask

    task automatic test_wrap();
        logic [15:0] exp_a [4];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF;
        exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        clear_logs();
        prog(0, 16'hFFFE, 16'h00A0, 8'd0);
        wr_reg(16'h0100, 8'h01);
        wait_idle("wrap");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= ra.size() || ra[i] !== exp_a[i]) begin
                errors++; $display("FAIL wrap_rd%0d want %h", i, exp_a[i]);
            end
            checks++;
            if (i >= wd.size() || wd[i] !== pat(exp_a[i])) begin
                errors++; $display("FAIL wrap_data%0d want %h", i, pat(exp_a[i]));
            end
        end
        do_ack(2'b01);
    endtask

    task automatic test_abort();
        int t;
        int n0;
        clear_logs();
        prog(0, 16'h0200, 16'h0300, 8'd3);
        wr_reg(16'h0100, 8'h01);
        t = cyc;
        while (cyc < t + 4) @(negedge clk);
        #1;
        n0 = wa.size();
        auxdaddr = 16'h0100;
        auxdin   = 8'h80;
        auxwe    = 1'b1;
        @(posedge clk);
        #1;
        auxwe = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 2'b00) begin
            errors++; $display("FAIL abort_busy got %b want 00", busy);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL abort_irq got %b want 0", irq);
        end
        checks++;
        if (n0 < 1 || wa.size() > n0 + 1) begin
            errors++; $display("FAIL abort_writes got %0d want <= %0d",
                               wa.size(), n0 + 1);
        end
    endtask

    task automatic test_rst_mid();
        int n;
        clear_logs();
        prog(0, 16'h0400, 16'h0500, 8'd3);
        wr_reg(16'h0100, 8'h01);
        n = 0;
        while (extwe !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (extwe !== 1'b1) begin
            errors++; $display("FAIL rstmid_nowrite extwe=%b want 1", extwe);
        end
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({extwe, auxdoutsel, busy} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_out got %b want 0000",
                               {extwe, auxdoutsel, busy});
        end
        #1;
        rst = 1'b0;
        clear_logs();
        prog(0, 16'h0600, 16'h0700, 8'd0);
        wr_reg(16'h0100, 8'h01);
        wait_idle("restart");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= wa.size() ||
                {wa[i], wd[i]} !== {16'h0700 + 16'(i), pat(16'h0600 + 16'(i))}) begin
                errors++; $display("FAIL restart_wr%0d want %h/%h", i,
                                   16'h0700 + 16'(i), pat(16'h0600 + 16'(i)));
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL restart_irq got %b want 1", irq);
        end
        do_ack(2'b01);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        rst      = 1'b1;
        auxdaddr = '0;
        auxdin   = '0;
        auxwe    = 1'b0;
        ack      = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_dual();
        test_dst_fixed();
        test_wrap();
        test_abort();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
